// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Accepts a framed byte stream (16-bit word count, little-endian data words,
// XOR checksum), writes each assembled word to the instruction memory write
// port and holds the CPU in reset until a complete, verified image is loaded.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Widened so a 16-bit length compares against MAX_WORDS without truncation.
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    logic [15:0] len;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        accept;
    logic [15:0] len_full;

    assign accept   = in_valid & in_ready;
    // Full length as it becomes known on the LEN_HI byte.
    assign len_full = {in_data, len[7:0]};

    // Loader FSM with all outputs registered; in_ready and busy track the
    // LEN_LO..CSUM states and are updated on every transition into or out of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len           <= '0;
            csum          <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the default below is
            // overridden later in the same block, giving a single-cycle strobe.
            mem_we <= 1'b0;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state         <= LEN_LO;
                        in_ready      <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        cpu_hold      <= 1'b1;
                        words_written <= '0;
                        csum          <= '0;
                        byte_idx      <= '0;
                    end
                end

                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        csum     <= csum ^ in_data;
                        state    <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        csum      <= csum ^ in_data;
                        if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else if ({1'b0, len_full} > MAX_LEN) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                mem_we        <= 1'b1;
                                mem_wdata     <= {in_data, word_buf};
                                mem_addr      <= BASE_ADDR + {14'd0, words_written, 2'b00};
                                words_written <= words_written + 16'd1;
                                if (words_written == len - 16'd1) begin
                                    state <= CSUM;
                                end
                            end
                        endcase
                    end
                end

                CSUM: begin
                    if (accept) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed boot frames plus randomized
// frames, compared against a frame-level reference model of expected writes
// and final status.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks;
    int          n_pass;
    wr_t         got_q[$];
    wr_t         exp_q[$];
    logic [7:0]  f_bytes[$];
    logic [31:0] f_words[$];
    logic [15:0] f_len;
    logic [7:0]  f_csum_flip;
    bit          exp_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Capture every write strobe; words_written must advance with each one.
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we === 1'b1) begin
            got_q.push_back('{mem_addr, mem_wdata});
            check("ww_with_we", 32'(words_written), 32'(got_q.size()));
        end
    end

    // Reference model: serialise the image into a frame and list the writes
    // and final status the loader must produce.
    task automatic build_frame();
        logic [7:0] cs;
        f_bytes = {};
        exp_q   = {};
        f_bytes.push_back(f_len[7:0]);
        f_bytes.push_back(f_len[15:8]);
        if (int'(f_len) > MAXW) begin
            exp_done = 1'b0;
            return;
        end
        for (int i = 0; i < int'(f_len); i++) begin
            for (int k = 0; k < 4; k++) f_bytes.push_back(8'(f_words[i] >> (8 * k)));
            exp_q.push_back('{BASE + 32'(4 * i), f_words[i]});
        end
        cs = 8'h00;
        foreach (f_bytes[i]) cs = cs ^ f_bytes[i];
        f_bytes.push_back(cs ^ f_csum_flip);
        exp_done = (f_csum_flip == 8'h00);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_q = {};
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_error", 32'(error), 32'd0);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ww", 32'(words_written), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) check("byte_accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic idle_cycle(input bit pulse_start);
        start    = pulse_start;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: back-to-back; 1: one idle cycle between bytes; 2: random gaps.
    // Idle gaps inside a frame may carry start pulses, which must be ignored.
    task automatic run_frame(input int mode);
        int gaps;
        build_frame();
        do_start();
        foreach (f_bytes[i]) begin
            if (i > 0 && mode != 0) begin
                gaps = (mode == 1) ? 1 : int'($urandom_range(0, 3));
                for (int g = 0; g < gaps; g++) idle_cycle(1'($urandom_range(0, 1)));
            end
            send_byte(f_bytes[i]);
        end
        check("end_done", 32'(done), 32'(exp_done));
        check("end_error", 32'(error), 32'(!exp_done));
        check("end_hold", 32'(cpu_hold), 32'(!exp_done));
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("ww_final", 32'(words_written), 32'(exp_q.size()));
        check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("write_addr", got_q[i].addr, exp_q[i].addr);
            check("write_data", got_q[i].data, exp_q[i].data);
        end
        if (exp_q.size() > 0) check("addr_hold", mem_addr, exp_q[exp_q.size() - 1].addr);
        check("we_idle", 32'(mem_we), 32'd0);
    endtask

    task automatic set_t1();
        f_len       = 16'd2;
        f_words     = {32'h01D2_0537, 32'h0A55_0513};
        f_csum_flip = 8'h00;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // T1: reference boot image, back-to-back bytes.
        set_t1();
        run_frame(0);
        check("t1_csum_byte", 32'(f_bytes[10]), 32'h0000_00AA);
        if (got_q.size() == 2) begin
            check("t1_word0", got_q[0].data, 32'h01D2_0537);
            check("t1_word1", got_q[1].data, 32'h0A55_0513);
            check("t1_addr1", got_q[1].addr, 32'h0000_0004);
        end else begin
            check("t1_nwrites", 32'(got_q.size()), 32'd2);
        end

        // T2: same image with checksum 0xAB.
        set_t1();
        f_csum_flip = 8'h01;
        run_frame(0);

        // T3: LEN = 257 rejected straight after the length bytes.
        f_len = 16'd257;
        run_frame(0);

        // T4: empty image.
        f_len       = 16'd0;
        f_csum_flip = 8'h00;
        run_frame(0);

        // T5: T1 with in_valid toggling and ignored start pulses.
        set_t1();
        for (int r = 0; r < 3; r++) run_frame(1);

        // T6: reset after six bytes, then a clean reload.
        set_t1();
        build_frame();
        do_start();
        for (int i = 0; i < 6; i++) send_byte(f_bytes[i]);
        reset = 1'b1;
        #1;
        check("t6_ready", 32'(in_ready), 32'd0);
        check("t6_we", 32'(mem_we), 32'd0);
        check("t6_addr", mem_addr, 32'd0);
        check("t6_wdata", mem_wdata, 32'd0);
        check("t6_hold", 32'(cpu_hold), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ww", 32'(words_written), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_idle_ready", 32'(in_ready), 32'd0);
        check("t6_idle_hold", 32'(cpu_hold), 32'd1);
        set_t1();
        run_frame(0);

        // Largest legal image, then one word over the limit.
        f_len       = 16'(MAXW);
        f_csum_flip = 8'h00;
        f_words     = {};
        for (int i = 0; i < MAXW; i++) f_words.push_back($urandom);
        run_frame(0);
        f_len = 16'(MAXW + 1);
        run_frame(2);

        // Randomized frames.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 9) == 0) f_len = 16'($urandom_range(MAXW + 1, 65535));
            else                           f_len = 16'($urandom_range(0, 8));
            f_words = {};
            for (int i = 0; i < 8; i++) f_words.push_back($urandom);
            f_csum_flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
